// File: rtl/ofdm_tx_pkg.sv
// ofdm_tx_pkg -- shared definitions for the 802.11 OFDM transmit chain
// (QPSK mapper, pilot insertion, IFFT, cyclic-prefix insertion).
//   NFFT       samples per OFDM symbol (power of two)
//   NCP        cyclic-prefix length, 0 < NCP < NFFT
//   DW         complex sample width, Re in the low half, Im in the high half
//   cplx_t     packed complex sample, layout identical to a DW-bit word
//   cp_state_t read-side states of the cyclic-prefix inserter
package ofdm_tx_pkg;

  localparam int NFFT   = 64;
  localparam int NCP    = 16;
  localparam int DW     = 32;

  localparam int RE_LSB = 0;
  localparam int RE_MSB = 15;
  localparam int IM_LSB = 16;
  localparam int IM_MSB = 31;

  typedef struct packed {
    logic signed [IM_MSB-IM_LSB:0] im;
    logic signed [RE_MSB-RE_LSB:0] re;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_BODY = 2'd2
  } cp_state_t;

  // Builds a DW-bit sample word from its real and imaginary parts.
  function automatic logic [DW-1:0] cplx_pack(input logic signed [15:0] re,
                                              input logic signed [15:0] im);
    cplx_t c;
    c.re = re;
    c.im = im;
    return c;
  endfunction

endpackage

// File: rtl/cp_sym_ram.sv
// cp_sym_ram -- simple dual-port symbol buffer holding two OFDM symbols.
// Address is {bank, idx}. Synchronous write; synchronous read with a read
// enable so the read data register holds its value while the consumer stalls.
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   re     read enable (rdata updates only when set)
//   raddr  read address
//   rdata  registered read data
module cp_sym_ram #(
  parameter int ABW = 7,
  parameter int DW  = 32
) (
  input  logic           clk,
  input  logic           we,
  input  logic [ABW-1:0] waddr,
  input  logic [DW-1:0]  wdata,
  input  logic           re,
  input  logic [ABW-1:0] raddr,
  output logic [DW-1:0]  rdata
);

  logic [DW-1:0] mem [2**ABW];
  logic [DW-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/cp_insert_802_11.sv
// cp_insert_802_11 -- cyclic-prefix insertion after the IFFT.
// Collects NFFT samples per symbol into a ping-pong buffer and emits, per
// symbol, the last NCP samples followed by all NFFT samples, gap-free.
//   clk, rst      clock, synchronous active-high reset
//   DAT_I         input sample            WE_I/STB_I/CYC_I  input qualifiers
//   ACK_O         input accept (combinational)
//   DAT_O         output sample           STB_O/WE_O        output valid
//   CYC_O         output frame active     ACK_I             downstream accept
module cp_insert_802_11 #(
  parameter int NFFT = ofdm_tx_pkg::NFFT,
  parameter int NCP  = ofdm_tx_pkg::NCP,
  parameter int DW   = ofdm_tx_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] DAT_I,
  input  logic          WE_I,
  input  logic          STB_I,
  input  logic          CYC_I,
  output logic          ACK_O,
  output logic [DW-1:0] DAT_O,
  output logic          WE_O,
  output logic          STB_O,
  output logic          CYC_O,
  input  logic          ACK_I
);

  import ofdm_tx_pkg::*;

  localparam int AW = $clog2(NFFT);
  localparam logic [AW-1:0] IDX_LAST = AW'(NFFT - 1);
  localparam logic [AW-1:0] CP_FIRST = AW'(NFFT - NCP);

  // Write side
  logic [1:0]    full_reg, full_next;
  logic          wr_bank_reg;
  logic [AW-1:0] wr_idx_reg;
  logic          wr_xfer, wr_wrap;

  // Read side: iss_bank_reg is the bank being addressed by the FSM, which runs
  // two pipeline stages ahead of rd_bank_reg, the bank currently draining out
  // of DAT_O. Keeping them apart lets the next symbol's prefix be addressed
  // while the previous symbol's tail is still in flight.
  cp_state_t     state_reg, state_next;
  logic [AW-1:0] rd_idx_reg, rd_idx_next;
  logic          iss_bank_reg, iss_bank_next;
  logic          rd_bank_reg;
  logic          issue, issue_last;
  logic [AW-1:0] issue_idx;

  // Output pipeline: RAM data register (stage 1) feeds DAT_O (stage 2).
  logic          v1_reg, v1_last_reg;
  logic          stb_reg, out_last_reg;
  logic [DW-1:0] dat_reg;
  logic [DW-1:0] ram_q;
  logic          adv, rd_xfer, rd_done;
  logic          cyc_reg, cyc_next, frm_act_reg;

  assign ACK_O   = STB_I & CYC_I & WE_I & ~full_reg[wr_bank_reg] & ~rst;
  assign wr_xfer = ACK_O;
  assign wr_wrap = wr_xfer & (wr_idx_reg == IDX_LAST);

  // Whole pipeline moves together; when the output register is stalled the
  // RAM read is withheld so its data register keeps the next sample.
  assign adv     = ~stb_reg | ACK_I;
  assign rd_xfer = stb_reg & ACK_I;
  assign rd_done = rd_xfer & out_last_reg;

  // A bank fills on its last write and frees when its last sample leaves DAT_O.
  // Both can happen in one cycle, always on different banks.
  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    assign full_next[gi] = (wr_wrap && (wr_bank_reg == 1'(gi))) ? 1'b1 :
                           (rd_done && (rd_bank_reg == 1'(gi))) ? 1'b0 :
                           full_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg    <= '0;
      wr_bank_reg <= 1'b0;
      wr_idx_reg  <= '0;
      rd_bank_reg <= 1'b0;
    end else begin
      full_reg <= full_next;
      if (wr_xfer) begin
        wr_idx_reg <= wr_idx_reg + 1'b1;
        if (wr_wrap) begin
          wr_bank_reg <= ~wr_bank_reg;
        end
      end
      if (rd_done) begin
        rd_bank_reg <= ~rd_bank_reg;
      end
    end
  end

  // Read FSM: issues one RAM address per advancing cycle. From IDLE the first
  // prefix address goes out immediately so the first sample appears two edges
  // after the symbol completes.
  always_comb begin
    state_next    = state_reg;
    rd_idx_next   = rd_idx_reg;
    iss_bank_next = iss_bank_reg;
    issue         = 1'b0;
    issue_last    = 1'b0;
    issue_idx     = rd_idx_reg;
    if (adv) begin
      case (state_reg)
        ST_IDLE: begin
          if (full_reg[iss_bank_reg]) begin
            issue       = 1'b1;
            issue_idx   = CP_FIRST;
            rd_idx_next = CP_FIRST + 1'b1;
            state_next  = (CP_FIRST == IDX_LAST) ? ST_BODY : ST_CP;
          end
        end
        ST_CP: begin
          issue       = 1'b1;
          rd_idx_next = rd_idx_reg + 1'b1;
          if (rd_idx_reg == IDX_LAST) begin
            state_next = ST_BODY;
          end
        end
        ST_BODY: begin
          issue       = 1'b1;
          rd_idx_next = rd_idx_reg + 1'b1;
          if (rd_idx_reg == IDX_LAST) begin
            issue_last    = 1'b1;
            iss_bank_next = ~iss_bank_reg;
            if (full_reg[~iss_bank_reg]) begin
              state_next  = ST_CP;
              rd_idx_next = CP_FIRST;
            end else begin
              state_next  = ST_IDLE;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rd_idx_reg   <= '0;
      iss_bank_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_idx_reg   <= rd_idx_next;
      iss_bank_reg <= iss_bank_next;
    end
  end

  cp_sym_ram #(
    .ABW(AW + 1),
    .DW (DW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_xfer),
    .waddr({wr_bank_reg, wr_idx_reg}),
    .wdata(DAT_I),
    .re   (issue),
    .raddr({iss_bank_reg, issue_idx}),
    .rdata(ram_q)
  );

  // The last-sample tag travels with the data so the bank is released only
  // once its final sample has actually been accepted downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg       <= 1'b0;
      v1_last_reg  <= 1'b0;
      stb_reg      <= 1'b0;
      out_last_reg <= 1'b0;
      dat_reg      <= '0;
    end else if (adv) begin
      v1_reg       <= issue;
      v1_last_reg  <= issue_last;
      stb_reg      <= v1_reg;
      out_last_reg <= v1_last_reg;
      dat_reg      <= v1_reg ? ram_q : '0;
    end
  end

  assign cyc_next = (state_reg != ST_IDLE) | full_reg[0] | full_reg[1] |
                    (CYC_I & frm_act_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_reg     <= 1'b0;
      frm_act_reg <= 1'b0;
    end else begin
      cyc_reg <= cyc_next;
      if (rd_xfer) begin
        frm_act_reg <= 1'b1;
      end else if (cyc_reg && !cyc_next) begin
        frm_act_reg <= 1'b0;
      end
    end
  end

  assign DAT_O = dat_reg;
  assign STB_O = stb_reg;
  assign WE_O  = stb_reg;
  assign CYC_O = cyc_reg;

endmodule
